// File: rtl/fns_tsv_encoder.sv
// Serial Fibonacci-numeral-system TSV encoder.
// Greedy MSB-first subtraction of per-TSV FNS weights from the input word,
// one TSV per cycle. Disabled TSVs are forced to 0 in the codeword.
// Optional feature macro: FNS_ENC_ERRCHK_EN. When it is defined, err flags a
// non-zero residue left after encoding. When it is not defined, err is tied to 0.
module fns_tsv_encoder #(
    parameter int unsigned N_TSV  = 5,
    parameter int unsigned WT_W   = 3,
    parameter int unsigned DATA_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_TSV-1:0]        en_flag,
    input  logic [N_TSV*WT_W-1:0]   weights,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_TSV-1:0]        code_out,
    output logic                    err
);

    localparam int unsigned IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_TSV - 1);

    typedef enum logic [1:0] {StIdle, StEnc, StDone} state_e;

    state_e                  state_q, state_d;
    logic [WT_W-1:0]         residue_q, residue_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_TSV-1:0]        en_snap_q, en_snap_d;
    logic [N_TSV*WT_W-1:0]   w_snap_q, w_snap_d;
    logic [N_TSV-1:0]        code_q, code_d;

    logic [WT_W-1:0]         cur_w;
    logic                    cur_en;
    logic [N_TSV-1:0]        sel;
    logic                    take;

    // Pick out the snapshotted weight/enable of the TSV at idx, plus its one-hot position
    always_comb begin
        cur_w  = '0;
        cur_en = 1'b0;
        sel    = '0;
        for (int unsigned i = 0; i < N_TSV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_w  = w_snap_q[i*WT_W +: WT_W];
                cur_en = en_snap_q[i];
                sel[i] = 1'b1;
            end
        end
    end

    // Bit is set when the TSV is usable and its weight still fits in the residue
    assign take = cur_en && (residue_q >= cur_w);

    // Next-state and datapath update for the IDLE -> ENC -> DONE sequence
    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        idx_d     = idx_q;
        en_snap_d = en_snap_q;
        w_snap_d  = w_snap_q;
        code_d    = code_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    residue_d = WT_W'(data_in);
                    en_snap_d = en_flag;
                    w_snap_d  = weights;
                    code_d    = '0;
                    idx_d     = IDX_TOP;
                    state_d   = StEnc;
                end
            end
            StEnc: begin
                if (take) begin
                    code_d    = code_q | sel;
                    residue_d = residue_q - cur_w;
                end
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            residue_q <= '0;
            idx_q     <= IDX_TOP;
            en_snap_q <= '0;
            w_snap_q  <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            idx_q     <= idx_d;
            en_snap_q <= en_snap_d;
            w_snap_q  <= w_snap_d;
            code_q    <= code_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign code_out  = code_q;

`ifdef FNS_ENC_ERRCHK_EN
    // Leftover residue means the word exceeds the sum of the enabled weights
    assign err = (state_q == StDone) && (residue_q != '0);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fns_tsv_encoder.sv
// Directed bench for fns_tsv_encoder: table of words with hand-computed codewords,
// plus hand-written back-pressure, input-scramble and mid-word reset sequences.
// Weight width is widened to 4 bits so that words above 7 can be exercised.
module tb_fns_tsv_encoder;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned TO = 40;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   en_flag;
    logic [N*W-1:0] weights;
    logic           in_valid;
    logic           in_ready;
    logic [D-1:0]   data_in;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   code_out;
    logic           err;

    int n_checks;
    int n_fail;

    fns_tsv_encoder #(
        .N_TSV  (N),
        .WT_W   (W),
        .DATA_W (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_flag   (en_flag),
        .weights   (weights),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] w;
        logic [N-1:0]   en;
        logic [D-1:0]   d;
        logic [N-1:0]   code;
        logic           rem;   // residue non-zero after encoding
        int             hold;  // cycles of out_ready=0 in DONE
        bit             scramble;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic rem);
`ifdef FNS_ENC_ERRCHK_EN
        return rem;
`else
        return 1'b0 & rem;
`endif
    endfunction

    // Apply one word, wait for the result, check it, hold it, then release it
    task automatic run_word(input vec_t v, input int id);
        int lat;
        logic [N-1:0] c0;
        logic e0;
        check($sformatf("v%0d in_ready idle", id), int'(in_ready), 1);
        weights   = v.w;
        en_flag   = v.en;
        data_in   = v.d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("v%0d in_ready enc", id), int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < TO) begin
            if (v.scramble) begin
                weights  = N*W'($urandom);
                en_flag  = N'($urandom);
                data_in  = D'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        // cycles counted from the accept cycle to the first out_valid cycle
        check($sformatf("v%0d latency", id), lat + 1, N + 1);
        check($sformatf("v%0d code_out", id), int'(code_out), int'(v.code));
        check($sformatf("v%0d err", id), int'(err), int'(exp_err(v.rem)));
        c0 = code_out;
        e0 = err;
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d hold%0d valid", id, k), int'(out_valid), 1);
            check($sformatf("v%0d hold%0d ready", id, k), int'(in_ready), 0);
            check($sformatf("v%0d hold%0d code", id, k), int'(code_out), int'(c0));
            check($sformatf("v%0d hold%0d err", id, k), int'(err), int'(e0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("v%0d released", id), int'(out_valid), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en_flag   = '0;
        weights   = '0;
        data_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        //           weights TSV4..TSV0               en        data    code      rem  hold sc
        vecs[0] = '{{4'd5, 4'd3, 4'd2, 4'd1, 4'd1}, 5'b11111, 4'd7,  5'b10100, 1'b0, 0, 1'b0};
        vecs[1] = '{{4'd3, 4'd2, 4'd1, 4'd0, 4'd1}, 5'b11101, 4'd4,  5'b10100, 1'b0, 0, 1'b0};
        vecs[2] = '{{4'd5, 4'd3, 4'd2, 4'd1, 4'd1}, 5'b11111, 4'd13, 5'b11111, 1'b1, 0, 1'b0};
        vecs[3] = '{{4'd5, 4'd3, 4'd2, 4'd1, 4'd1}, 5'b11111, 4'd0,  5'b00000, 1'b0, 0, 1'b0};
        vecs[4] = '{{4'd5, 4'd3, 4'd2, 4'd1, 4'd1}, 5'b00000, 4'd6,  5'b00000, 1'b1, 0, 1'b0};
        vecs[5] = '{{4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 5'b11111, 4'd3,  5'b11111, 1'b1, 0, 1'b0};
        vecs[6] = '{{4'd8, 4'd5, 4'd3, 4'd2, 4'd1}, 5'b11111, 4'd12, 5'b10101, 1'b0, 0, 1'b0};
        vecs[7] = '{{4'd8, 4'd5, 4'd3, 4'd2, 4'd1}, 5'b11111, 4'd15, 5'b11010, 1'b0, 10, 1'b0};
        vecs[8] = '{{4'd8, 4'd5, 4'd3, 4'd2, 4'd1}, 5'b01111, 4'd9,  5'b01101, 1'b0, 0, 1'b1};
        vecs[9] = '{{4'd5, 4'd3, 4'd2, 4'd1, 4'd1}, 5'b11111, 4'd7,  5'b10100, 1'b0, 2, 1'b1};

        #12;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset code_out", int'(code_out), 0);
        check("reset err", int'(err), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i], i);
        end

        // Reset during ENC with idx=2: bit4 already set, then reset clears everything
        weights  = {4'd5, 4'd3, 4'd2, 4'd1, 4'd1};
        en_flag  = 5'b11111;
        data_in  = 4'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset partial code", int'(code_out), int'(5'b10000));
        #2 rst_n = 1'b0;
        #1;
        check("async reset in_ready", int'(in_ready), 1);
        check("async reset out_valid", int'(out_valid), 0);
        check("async reset code_out", int'(code_out), 0);
        check("async reset err", int'(err), 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_word(vecs[6], 100);
        run_word(vecs[2], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
